// File: rtl/sat_accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sat_accum_sequencer
// Description : Reduces a programmed number of streamed operands into a
//               signed saturating accumulator with sticky overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_accum_sequencer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [WIDTH-1:0]     init,
    input  logic                 abort,
    output logic                 busy,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_po,
    output logic                 out_no,
    output logic [CNT_WIDTH-1:0] out_sat_cnt
);

    localparam logic [WIDTH-1:0]     c_pos_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     c_neg_max = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_cnt_zero = {CNT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [CNT_WIDTH-1:0] r_rem;
    logic                 r_po;
    logic                 r_no;
    logic [CNT_WIDTH-1:0] r_sat_cnt;

    logic [WIDTH-1:0]     w_sum;
    logic                 w_po;
    logic                 w_no;
    logic [WIDTH-1:0]     w_step;

    // Overflow is only possible when both operands share a sign and the
    // wrapped sum flips it.
    assign w_sum  = r_acc + in_data;
    assign w_po   = ~r_acc[WIDTH-1] & ~in_data[WIDTH-1] &  w_sum[WIDTH-1];
    assign w_no   =  r_acc[WIDTH-1] &  in_data[WIDTH-1] & ~w_sum[WIDTH-1];
    assign w_step = w_po ? c_pos_max : (w_no ? c_neg_max : w_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_rem     <= '0;
            r_po      <= 1'b0;
            r_no      <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc     <= init;
                        r_rem     <= len;
                        r_po      <= 1'b0;
                        r_no      <= 1'b0;
                        r_sat_cnt <= '0;
                        r_state   <= (len == c_cnt_zero) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        r_acc <= w_step;
                        r_po  <= r_po | w_po;
                        r_no  <= r_no | w_no;
                        if ((w_po || w_no) && (r_sat_cnt != c_cnt_max)) begin
                            r_sat_cnt <= r_sat_cnt + c_cnt_one;
                        end
                        r_rem <= r_rem - c_cnt_one;
                        if (r_rem == c_cnt_one) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (abort || out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_ACCUM) || (r_state == S_DONE);
    assign in_ready    = (r_state == S_ACCUM);
    assign out_valid   = (r_state == S_DONE);
    assign out_result  = r_acc;
    assign out_po      = r_po;
    assign out_no      = r_no;
    assign out_sat_cnt = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sat_accum_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sat_accum_sequencer
// Description : Randomized self-checking bench against an integer-arithmetic
//               reference model of the saturating reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_accum_sequencer;

    localparam int c_w  = 8;
    localparam int c_cw = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [c_cw-1:0] len;
    logic [c_w-1:0]  init;
    logic            abort;
    logic            busy;
    logic            in_valid;
    logic [c_w-1:0]  in_data;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [c_w-1:0]  out_result;
    logic            out_po;
    logic            out_no;
    logic [c_cw-1:0] out_sat_cnt;

    sat_accum_sequencer #(.WIDTH(c_w), .CNT_WIDTH(c_cw)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .init       (init),
        .abort      (abort),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_po     (out_po),
        .out_no     (out_no),
        .out_sat_cnt(out_sat_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_acc;
    int m_cnt;
    bit m_po;
    bit m_no;
    int ops[$];
    int cyc;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Reference: exact integer sum, then clamp to the representable range.
    task automatic model_step(input int d);
        int s;
        bit sat;
        s   = m_acc + d;
        sat = 1'b0;
        if (s > 127) begin
            s = 127; m_po = 1'b1; sat = 1'b1;
        end else if (s < -128) begin
            s = -128; m_no = 1'b1; sat = 1'b1;
        end
        if (sat && m_cnt < 15) m_cnt++;
        m_acc = s;
    endtask

    task automatic model_clear(input int init_v);
        m_acc = init_v; m_po = 1'b0; m_no = 1'b0; m_cnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_result"}, $signed(out_result), m_acc);
        check({tag, "_po"}, out_po, m_po);
        check({tag, "_no"}, out_no, m_no);
        check({tag, "_satcnt"}, out_sat_cnt, m_cnt);
    endtask

    function automatic int rand_byte();
        logic [7:0] r;
        r = 8'($urandom);
        return int'($signed(r));
    endfunction

    task automatic do_reduction(input int init_v, input int n, input int gmin,
                                input int gmax, input int bp, input bit abort_at_start,
                                input bit start_busy, input bit start_done);
        int d;
        int g;
        start = 1'b1; len = c_cw'(n); init = c_w'(init_v); abort = abort_at_start;
        model_clear(init_v);
        cyc = 0;
        tick();
        start = 1'b0; abort = 1'b0;
        if (n == 0) check("zero_len_in_ready", in_ready, 1'b0);
        for (int k = 0; k < n; k++) begin
            if (k == 0 && start_busy) begin
                start = 1'b1; len = c_cw'(2); init = '0;
            end
            g = $urandom_range(gmax, gmin);
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                tick();
                start = 1'b0;
            end
            check("accum_in_ready", in_ready, 1'b1);
            check("accum_out_valid", out_valid, 1'b0);
            d = (ops.size() > 0) ? ops.pop_front() : rand_byte();
            in_valid = 1'b1; in_data = c_w'(d);
            tick();
            in_valid = 1'b0; start = 1'b0;
            model_step(d);
        end
        check("done_out_valid", out_valid, 1'b1);
        check("done_busy", busy, 1'b1);
        check("done_in_ready", in_ready, 1'b0);
        if (gmax == 0) check("latency", cyc, n + 1);
        check_outputs("done");
        for (int j = 0; j < bp; j++) begin
            out_ready = 1'b0;
            if (start_done) begin
                start = 1'b1; len = c_cw'(1); init = c_w'(99);
            end
            tick();
            start = 1'b0;
            check("stall_out_valid", out_valid, 1'b1);
            check_outputs("stall");
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ack_out_valid", out_valid, 1'b0);
        check("ack_busy", busy, 1'b0);
        check_outputs("idle_hold");
        tick();
        check("idle_in_ready", in_ready, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; init = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        model_clear(0);
        check_outputs("rst");
        rst = 1'b0;
        tick();

        // Positive clamp, back-to-back operands
        ops = '{100, 50, -10};
        do_reduction(0, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("pos_clamp_result", $signed(out_result), 117);

        // Negative clamp
        ops = '{-50, -1};
        do_reduction(-100, 2, 0, 0, 1, 1'b0, 1'b0, 1'b0);
        check("neg_clamp_cnt", out_sat_cnt, 2);

        // Zero length, with abort in IDLE alongside the start
        do_reduction(42, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Bubbles and backpressure, start ignored while DONE
        ops = '{3, 4};
        do_reduction(0, 2, 2, 2, 3, 1'b0, 1'b0, 1'b1);
        check("bubble_result", $signed(out_result), 7);

        // Abort concurrently with a valid operand
        start = 1'b1; len = c_cw'(3); init = c_w'(10);
        model_clear(10);
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = c_w'(5);
        tick();
        model_step(5);
        in_data = c_w'(20); abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        for (int j = 0; j < 3; j++) begin
            check("abort_out_valid", out_valid, 1'b0);
            tick();
        end
        check_outputs("abort");

        // Reset while a result is pending
        start = 1'b1; len = '0; init = c_w'(42);
        tick();
        start = 1'b0;
        check("pre_rst_out_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_done_out_valid", out_valid, 1'b0);
        check("rst_done_busy", busy, 1'b0);
        model_clear(0);
        check_outputs("rst_done");
        tick();

        // Counter ceiling, then again with an ignored start while busy
        for (int j = 0; j < 15; j++) ops.push_back(1);
        do_reduction(127, 15, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("ceiling_cnt", out_sat_cnt, 15);
        for (int j = 0; j < 15; j++) ops.push_back(1);
        do_reduction(127, 15, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        check("ceiling_busy_start_po", out_po, 1'b1);

        // Randomized reductions
        for (int t = 0; t < 30; t++) begin
            do_reduction(rand_byte(), $urandom_range(15, 0), 0, $urandom_range(2, 0),
                         $urandom_range(2, 0), 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sat_accum_sequencer.md
# sat_accum_sequencer

Multi-cycle controller that sequences one signed saturating adder (the codebase's `no_overflow_adder`) over a stream of operands.

- It reduces a programmed number of operands into a single clamped accumulator value.
- It reports sticky positive and negative overflow flags and a count of saturation events.
- It sits between a producer (valid/ready operand stream) and a consumer (valid/ready result). Typical users are DSP-style extension instructions and performance-counter reductions.

## Interface

Parameters:
- `WIDTH`, 32: operand, accumulator and result width, signed two's complement.
- `CNT_WIDTH`, 8: width of the length and saturation counters.

Ports:
- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a reduction. Accepted only in IDLE.
- `len`  in  CNT_WIDTH: number of operands to consume. Sampled with `start`.
- `init`  in  WIDTH: initial accumulator value. Sampled with `start`.
- `abort`  in  1: cancel the current reduction and return to IDLE.
- `busy`  out  1: high in ACCUM and DONE.
- `in_valid`  in  1: operand valid.
- `in_data`  in  WIDTH: operand.
- `in_ready`  out  1: high exactly in ACCUM.
- `out_valid`  out  1: high exactly in DONE.
- `out_ready`  in  1: consumer accepts the result.
- `out_result`  out  WIDTH: accumulator value.
- `out_po`  out  1: sticky flag, at least one step clamped to the positive maximum (0111…1).
- `out_no`  out  1: sticky flag, at least one step clamped to the negative maximum (1000…0).
- `out_sat_cnt`  out  CNT_WIDTH: number of clamped steps, saturating at all-ones.

## Operation

State machine with states IDLE, ACCUM and DONE, held in a registered state variable.

- **IDLE:** `start`=1 loads `acc`←`init`, `rem`←`len`, and clears `out_po`, `out_no` and `out_sat_cnt`.
  - If `len`≠0, go to ACCUM.
  - If `len`=0, go directly to DONE with `out_result`=`init`.
  - `start` in any other state is ignored.
- **ACCUM:** each operand handshake (`in_valid`&&`in_ready`) does the following:
  - `acc`←saturating sum of `acc` and `in_data`.
  - `out_po`|=PO and `out_no`|=NO.
  - If PO or NO, `out_sat_cnt`++ (it stops at 2^CNT_WIDTH−1).
  - `rem`−−.
  - The handshake that takes `rem` from 1 to 0 moves the FSM to DONE.
  - Cycles with no handshake leave all state unchanged.
- **DONE:** `out_result`, flags and count are held stable while `out_valid`=1. A cycle with `out_ready`=1 returns the FSM to IDLE.
- **Arithmetic:**
  - A plain WIDTH-bit sum.
  - PO = both operands non-negative and the sum negative; the result clamps to 0111…1.
  - NO = both operands negative and the sum non-negative; the result clamps to 1000…0.
  - Mixed signs never saturate.
- **`abort`** (ACCUM or DONE) returns the FSM to IDLE on the next edge.
  - No result is presented, and an operand offered in that cycle is not consumed.
  - `abort` in IDLE has no effect, and `start` in that same cycle is still honoured.
  - In ACCUM, `abort` has priority over a concurrent handshake.
  - In DONE, `abort` has priority over `out_ready`.
- **Outputs in IDLE:**
  - `out_result`, `out_po`, `out_no` and `out_sat_cnt` keep their last values.
  - `out_valid`=0.

## Timing

- **Reset:**
  - state=IDLE; `busy`=0, `in_ready`=0, `out_valid`=0.
  - `out_result`=0, `out_po`=0, `out_no`=0, `out_sat_cnt`=0; `rem`=0.
  - Reset in any state, including mid-reduction or with a result pending, takes effect at the next edge and discards the operation.
- **Output derivation:** `in_ready`, `out_valid` and `busy` are decoded from the state register only. There is no combinational path from `in_valid`, `out_ready` or `start`.
- **Start latency:** `start` accepted at edge T means `in_ready`=1 from cycle T+1.
- **`len`=0:** `out_valid`=1 from cycle T+1.
- **Result latency:** the final operand handshake at edge T means `out_valid`=1 in cycle T+1 with the updated result. There is one cycle of latency per operand and full throughput of one operand per cycle.
- **Minimum reduction:** for `len`=N with `in_valid` held high, the reduction takes N+1 cycles from `start` to `out_valid`.
- **Back-to-back:** the result is accepted at edge T (FSM to IDLE). The earliest next `start` is sampled in cycle T+1, so there is one mandatory IDLE cycle.
- **Bubbles:** `in_valid` gaps in ACCUM and `out_ready` backpressure in DONE may last indefinitely without corrupting state.

## Test plan

All cases use WIDTH=8 and CNT_WIDTH=4.

- **Positive clamp:** `init`=0, `len`=3, operands 100, 50, −10 streamed back-to-back → steps give 100, 127 (clamped), 117. `out_result`=117, `out_po`=1, `out_no`=0, `out_sat_cnt`=1, `out_valid` 4 cycles after `start`.
- **Negative clamp:** `init`=−100, `len`=2, operands −50, −1 → −128, then −128 (clamped). `out_result`=−128, `out_no`=1, `out_sat_cnt`=2.
- **Zero length:** `len`=0, `init`=42 → `in_ready` never rises. `out_valid`=1 the cycle after `start` with `out_result`=42 and flags 0.
- **Bubbles and backpressure:** `len`=2, operands 3 and 4 with 2-cycle `in_valid` gaps, `out_ready` low for 3 cycles.
  - `out_result`=7 is held stable for all 3 stalled cycles.
  - The FSM returns to IDLE the edge after `out_ready`=1.
  - A `start` asserted while DONE is ignored.
- **Abort and reset:**
  - `abort` after 1 of 3 operands, asserted concurrently with a valid operand → IDLE next edge, operand not consumed, `out_valid` never asserted.
  - Separately, `rst` in DONE → all outputs at reset values next cycle.
- **Counter ceiling:** `init`=127, `len`=15, all operands 1 → `out_result`=127, `out_po`=1, `out_sat_cnt`=15.
  - Repeat with `len`=15 preceded by `start` while busy: the ignored `start` must not reload `rem`.
